// File: rtl/mem_refill_if.sv
// Refill read channel between a cache and its memory-side responder.
// Ports: rreq/raddr travel cache -> memory; rdata/rvalid/rlast carry the burst
// back, busy/drop_err report responder status. master = cache, slave = memory.
interface mem_refill_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              rreq;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rlast;
  logic              busy;
  logic              drop_err;

  modport master (
    output rreq, raddr,
    input  rdata, rvalid, rlast, busy, drop_err
  );

  modport slave (
    input  rreq, raddr,
    output rdata, rvalid, rlast, busy, drop_err
  );
endinterface

// File: rtl/mem_refill_responder.sv
// Memory-side refill responder: returns an aligned line as BURST_LEN words of an address-derived pattern.
// Latency: first beat exactly LATENCY cycles after rreq is sampled in IDLE; then one beat per cycle.
// Backpressure: none; requests seen while busy are dropped and latch the sticky drop_err flag.
// Ports: clk, reset (sync, active-low), bus (mem_refill_if.slave: rreq/raddr in;
// rdata/rvalid/rlast/busy/drop_err out).
module mem_refill_responder #(
  parameter int LATENCY   = 8,
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32
) (
  input  logic         clk,
  input  logic         reset,
  mem_refill_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] BURST = 2'd2;

  // Clears the byte offset within a line (line = BURST_LEN 32-bit words).
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(BURST_LEN * 4 - 1));
  // The accepting edge already accounts for one cycle of latency.
  localparam logic [7:0]        LAT_INIT  = 8'(LATENCY - 1);
  localparam logic [4:0]        LAST_BEAT = 5'(BURST_LEN - 1);

  logic [1:0]        state;
  logic [7:0]        lat_cnt;
  logic [4:0]        beat;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic              drop_q;

  // B(A) = A[7:0] + A[ADDR_W-1:8], modulo 256.
  function automatic logic [7:0] pat_byte(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] hi;
    hi = a >> 8;
    return a[7:0] + hi[7:0];
  endfunction

  // Word idx of the line at b; b is line-aligned so b+4*idx+3 never wraps.
  function automatic logic [DATA_W-1:0] line_word(input logic [ADDR_W-1:0] b,
                                                  input logic [4:0]        idx);
    logic [ADDR_W-1:0] w;
    w = b + ADDR_W'({idx, 2'b00});
    return {pat_byte(w + ADDR_W'(3)), pat_byte(w + ADDR_W'(2)),
            pat_byte(w + ADDR_W'(1)), pat_byte(w)};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      lat_cnt  <= 8'd0;
      beat     <= 5'd0;
      base     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      // Any request outside IDLE (including the last-beat cycle) is lost.
      if (bus.rreq && state != IDLE) drop_q <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.rreq) begin
            base <= bus.raddr & LINE_MASK;
            beat <= 5'd0;
            if (LATENCY == 1) begin
              // Zero wait: first beat is registered on the accepting edge.
              state    <= BURST;
              rvalid_q <= 1'b1;
              rlast_q  <= (LAST_BEAT == 5'd0);
              rdata_q  <= line_word(bus.raddr & LINE_MASK, 5'd0);
            end else begin
              state   <= WAIT;
              lat_cnt <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == 8'd1) begin
            state    <= BURST;
            rvalid_q <= 1'b1;
            rlast_q  <= (LAST_BEAT == 5'd0);
            rdata_q  <= line_word(base, 5'd0);
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        BURST: begin
          if (beat == LAST_BEAT) begin
            state    <= IDLE;
            beat     <= 5'd0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
          end else begin
            beat    <= beat + 5'd1;
            rdata_q <= line_word(base, beat + 5'd1);
            rlast_q <= ((beat + 5'd1) == LAST_BEAT);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rlast    = rlast_q;
  assign bus.busy     = (state != IDLE);
  assign bus.drop_err = drop_q;

endmodule
